// File: rtl/iq_impair_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iq_impair_gen : burst quadrature tone with gain/phase/DC impairments,    |
// |                 quantised to 4-bit offset binary.   Rev 1.0              |
// +--------------------------------------------------------------------------+
module iq_impair_gen #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ACC_W-1:0]        freq_word,
  input  logic [CNT_W-1:0]        num_samples,
  input  logic [7:0]              gain_q,
  input  logic signed [7:0]       phase_p,
  input  logic signed [7:0]       dc_i,
  input  logic signed [7:0]       dc_q,
  output logic [3:0]              Ix,
  output logic [3:0]              Qx,
  output logic                    iq_valid,
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

  // First quadrant of round(127*sin(2*pi*k/64)), k = 0..16
  function automatic logic signed [7:0] qtab(input logic [4:0] i);
    case (i)
      5'd0:  qtab = 8'sd0;    5'd1:  qtab = 8'sd12;   5'd2:  qtab = 8'sd25;
      5'd3:  qtab = 8'sd37;   5'd4:  qtab = 8'sd49;   5'd5:  qtab = 8'sd60;
      5'd6:  qtab = 8'sd71;   5'd7:  qtab = 8'sd81;   5'd8:  qtab = 8'sd90;
      5'd9:  qtab = 8'sd98;   5'd10: qtab = 8'sd106;  5'd11: qtab = 8'sd112;
      5'd12: qtab = 8'sd117;  5'd13: qtab = 8'sd122;  5'd14: qtab = 8'sd125;
      5'd15: qtab = 8'sd126;  5'd16: qtab = 8'sd127;
      default: qtab = 8'sd0;
    endcase
  endfunction

  function automatic logic signed [7:0] lut_sin(input logic [5:0] k);
    logic signed [7:0] m;
    m = k[4] ? qtab(5'd16 - {1'b0, k[3:0]}) : qtab({1'b0, k[3:0]});
    lut_sin = k[5] ? -m : m;
  endfunction

  function automatic logic [3:0] quant(input logic signed [11:0] v);
    logic [7:0] v8;
    if (v > 12'sd127)       v8 = 8'h7F;
    else if (v < -12'sd128) v8 = 8'h80;
    else                    v8 = v[7:0];
    quant = {~v8[7], v8[6:4]};
  endfunction

  logic [1:0]        r_state, w_next;
  logic [ACC_W-1:0]  r_acc, r_freq;
  logic [CNT_W-1:0]  r_cnt, r_num;
  logic [7:0]        r_gain;
  logic signed [7:0] r_phase, r_dci, r_dcq;

  logic              r_v1, r_v2, r_v3;
  logic signed [7:0] r_c1, r_s1, r_im2;
  logic signed [9:0] r_qm2;
  logic [11:0]       r_qg3, r_ig3;

  logic              w_issue, w_accept;
  logic [5:0]        w_idx;
  logic signed [15:0] w_qm_prod, w_qm_sum;
  logic signed [17:0] w_qg_prod;

  assign w_accept = (r_state == c_ST_IDLE) && start && !abort;
  assign w_issue  = (r_state == c_ST_RUN) && !abort;
  assign w_idx    = r_acc[ACC_W-1 -: 6];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (RESET) r_state <= c_ST_IDLE;
    else       r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (start) w_next = (num_samples == c_CNT_ZERO) ? c_ST_DONE : c_ST_RUN;
      c_ST_RUN:   if (r_cnt == r_num - c_CNT_ONE) w_next = c_ST_DRAIN;
      c_ST_DRAIN: if (!(r_v1 || r_v2 || r_v3)) w_next = c_ST_DONE;
      default:    w_next = c_ST_IDLE;
    endcase
    if (abort) w_next = c_ST_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_ST_RUN, c_ST_DRAIN: busy = 1'b1;
      c_ST_DONE:            done = 1'b1;
      default:              ;
    endcase
  end

  // Burst configuration is captured only on an accepted start
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_freq  <= '0;
      r_num   <= '0;
      r_gain  <= '0;
      r_phase <= '0;
      r_dci   <= '0;
      r_dcq   <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_freq  <= freq_word;
      r_num   <= num_samples;
      r_gain  <= gain_q;
      r_phase <= phase_p;
      r_dci   <= dc_i;
      r_dcq   <= dc_q;
    end else if (w_issue) begin
      r_acc <= r_acc + r_freq;
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  // ---------------- datapath ----------------
  assign w_qm_prod = r_phase * r_c1;
  assign w_qm_sum  = {r_s1[7], r_s1, 7'd0} + w_qm_prod;
  assign w_qg_prod = r_qm2 * $signed({1'b0, r_gain});

  always_ff @(posedge clk) begin
    r_c1  <= lut_sin(w_idx + 6'd16);
    r_s1  <= lut_sin(w_idx);
    r_qm2 <= 10'(w_qm_sum >>> 7);
    r_im2 <= r_c1;
    r_qg3 <= 12'(w_qg_prod >>> 7) + {{4{r_dcq[7]}}, r_dcq};
    r_ig3 <= {{4{r_im2[7]}}, r_im2} + {{4{r_dci[7]}}, r_dci};
  end

  // Valid pipeline; abort flushes it but leaves Ix/Qx holding
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      iq_valid <= 1'b0;
      Ix       <= 4'h8;
      Qx       <= 4'h8;
    end else if (abort) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      iq_valid <= 1'b0;
    end else begin
      r_v1     <= w_issue;
      r_v2     <= r_v1;
      r_v3     <= r_v2;
      iq_valid <= r_v3;
      if (r_v3) begin
        Ix <= quant(r_ig3);
        Qx <= quant(r_qg3);
      end
    end
  end

endmodule
`default_nettype wire
